// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: register-destination selects and
// the multiply/divide unit's operation and state encodings.
package mips_pkg;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring shift-subtract
// steps on magnitudes, followed by a sign-correction cycle that loads hi/lo.
module muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state;
  muldiv_op_t    op_q;
  logic [5:0]    cnt;
  logic [31:0]   acc;
  logic [31:0]   quo;
  logic [31:0]   mcand;
  logic          sign_a;
  logic          sign_b;
  logic          zero_div;

  muldiv_op_t    op_in;
  logic          signed_in;
  logic          sa_in;
  logic          sb_in;
  logic          is_div;
  logic [32:0]   add_x;
  logic [32:0]   add_y;
  logic [32:0]   sum;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix;
  logic [31:0]   rem_fix;

  assign op_in     = muldiv_op_t'(op);
  assign signed_in = (op_in == MULT) || (op_in == DIV);
  assign sa_in     = signed_in & a[31];
  assign sb_in     = signed_in & b[31];
  assign is_div    = (op_q == DIV) || (op_q == DIVU);

  // One 33-bit adder serves both paths: add for multiply, subtract for divide.
  always_comb begin
    add_x = is_div ? {acc, quo[31]} : {1'b0, acc};
    add_y = {1'b0, mcand};
    sum   = add_x + (add_y ^ {33{is_div}}) + 33'(is_div);
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -{acc, quo} : {acc, quo};
    quot_fix = zero_div ? 32'hFFFF_FFFF : ((sign_a ^ sign_b) ? -quo : quo);
    rem_fix  = sign_a ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= MULT;
      cnt      <= '0;
      acc      <= '0;
      quo      <= '0;
      mcand    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op_in;
            sign_a   <= sa_in;
            sign_b   <= sb_in;
            acc      <= '0;
            quo      <= sa_in ? -a : a;
            mcand    <= sb_in ? -b : b;
            zero_div <= op[1] && (b == 32'd0);
            cnt      <= '0;
            state    <= CALC;
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        CALC: begin
          if (is_div) begin
            // A clear borrow bit means the trial subtraction fits.
            if (!sum[32]) begin
              acc <= sum[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              acc <= add_x[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end else if (quo[0]) begin
            acc <= sum[32:1];
            quo <= {sum[0], quo[31:1]};
          end else begin
            acc <= {1'b0, acc[31:1]};
            quo <= {acc[0], quo[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITER_COUNT - 1)) state <= SIGN;
        end
        SIGN: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);
  assign div0 = done & zero_div;

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port a, input, 32 bits: multiplicand or dividend, taken from regfile read data 1.
REQ-006 SHALL have port b, input, 32 bits: multiplier or divisor, taken from regfile read data 2.
REQ-007 SHALL have ports wr_hi and wr_lo, input, 1 bit each: MTHI/MTLO strobes; each writes a into the selected register.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold a new result.
REQ-010 SHALL have port div0, output, 1 bit: asserted together with done when a divide had b == 0.
REQ-011 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers, read by MFHI/MFLO.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, SIGN, DONE.
REQ-013 SHALL, on the edge where start is 1 in IDLE: latch op, latch |a| and |b| (signed ops) or a and b (unsigned ops), latch the operand signs, clear the iteration counter, and enter CALC.
REQ-014 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly 32 cycles, then enter SIGN.
REQ-015 SHALL, in SIGN, apply sign correction and load hi/lo, then enter DONE.
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
REQ-016 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-017 SHALL drive busy = 1 in CALC and SIGN, and 0 otherwise.
REQ-018 Latency: start sampled at edge E0 -> busy from E0 -> hi/lo valid and done = 1 after edge E33 -> IDLE after E34.
REQ-019 SHALL produce multiply results as {hi, lo} = the 64-bit product.
REQ-020 SHALL produce divide results as lo = quotient, hi = remainder.
REQ-021 SHALL handle divide by zero as: lo = 32'hFFFFFFFF, hi = a (unchanged), div0 = 1 together with done; full latency is still taken.
REQ-022 SHALL return lo = 32'h80000000, hi = 0 for DIV with a = 32'h80000000 and b = 32'hFFFFFFFF, with no error flag.
REQ-023 SHALL ignore start, wr_hi and wr_lo whenever the FSM is not IDLE (including DONE).
REQ-024 SHALL, in IDLE, give start priority over wr_hi and wr_lo when they occur in the same cycle; the write is dropped.
REQ-025 SHALL allow wr_hi and wr_lo together in IDLE, with both hi and lo loaded from a.
REQ-026 SHALL hold hi and lo constant in every cycle except a SIGN-state load or an accepted wr_hi/wr_lo.

Reset
REQ-027 SHALL, when rst_n = 0, immediately force the state to IDLE, busy = 0, done = 0, div0 = 0, hi = 0, lo = 0, and the counter to 0.
REQ-028 SHALL, when reset is applied mid-operation, abort the operation with no done pulse and leave hi/lo at 0.
REQ-029 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the muldiv_op_t enum (MULT, MULTU, DIV, DIVU) and the state enum in the shared package mips_pkg, alongside the existing REGDST constants.
REQ-031 SHALL place ITER_COUNT = 32 in mips_pkg.
REQ-032 SHALL be implemented as a single module with no sub-module; one shared 33-bit adder/subtractor serves both multiply and divide.

Verification
REQ-033 Bench SHALL cover: MULTU a = 32'hFFFFFFFF, b = 32'h2 -> after 34 cycles hi = 32'h1, lo = 32'hFFFFFFFE, done pulse of 1 cycle.
REQ-034 Bench SHALL cover: MULT a = -3, b = 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB.
REQ-035 Bench SHALL cover: DIV a = -7, b = 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF; then DIVU a = 100, b = 0 -> lo = 32'hFFFFFFFF, hi = 100, div0 = 1.
REQ-036 Bench SHALL cover: start pulsed again and wr_lo = 1 while busy -> both ignored and the result is unchanged; wr_hi with start in IDLE -> hi not written.
REQ-037 Bench SHALL cover: rst_n = 0 at CALC cycle 15 -> busy = 0 and hi = lo = 0 at once, no done pulse, and a new start accepted right after release.
REQ-038 Bench SHALL cover: DIV a = 32'h80000000, b = -1 -> lo = 32'h80000000, hi = 0, div0 = 0.
